// File: rtl/mpu_register_file.sv
// Matrix register file: element-wise loads into MATRIX_REGISTERS x M x N float storage, and
// row-major streaming read-out of complete matrices with per-register validity tracking.

package global_defs;
  localparam int unsigned M                = 4;
  localparam int unsigned N                = 4;
  localparam int unsigned MBITS            = 2;
  localparam int unsigned NBITS            = 2;
  localparam int unsigned MATRIX_REGISTERS = 4;
  localparam int unsigned MATRIX_REG_BITS  = 2;

  typedef logic [31:0] float_sp;
endpackage

module mpu_register_file
  import global_defs::*;
(
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         reg_load_req_in,
  input  logic [MATRIX_REG_BITS:0]     reg_load_addr_in,
  input  float_sp                      reg_load_element_in,
  input  logic [MBITS:0]               reg_i_load_loc_in,
  input  logic [NBITS:0]               reg_j_load_loc_in,
  input  logic [MBITS:0]               reg_m_load_size_in,
  input  logic [NBITS:0]               reg_n_load_size_in,
  input  logic                         load_pending_in,
  output logic                         load_ready_out,
  input  logic                         store_req_in,
  input  logic [MATRIX_REG_BITS:0]     store_addr_in,
  output float_sp                      store_element_out,
  output logic [MBITS:0]               store_i_loc_out,
  output logic [NBITS:0]               store_j_loc_out,
  output logic [MBITS:0]               store_m_size_out,
  output logic [NBITS:0]               store_n_size_out,
  output logic                         store_valid_out,
  output logic                         store_done_out,
  output logic                         store_error_out,
  output logic [MATRIX_REGISTERS-1:0]  matrix_valid_out
);

  typedef enum logic [1:0] {RF_IDLE, RF_LOAD, RF_STORE} rf_state_e;

  localparam logic [MBITS:0]           MLim    = (MBITS + 1)'(M);
  localparam logic [NBITS:0]           NLim    = (NBITS + 1)'(N);
  localparam logic [MATRIX_REG_BITS:0] AddrLim = (MATRIX_REG_BITS + 1)'(MATRIX_REGISTERS);

  rf_state_e state_q, state_d;

  float_sp                        mem_q [MATRIX_REGISTERS][M][N];
  logic [MATRIX_REGISTERS-1:0]    valid_q;
  logic [MBITS:0]                 m_dim_q [MATRIX_REGISTERS];
  logic [NBITS:0]                 n_dim_q [MATRIX_REGISTERS];
  logic [MATRIX_REG_BITS:0]       load_addr_q;
  logic [MBITS:0]                 load_m_q;
  logic [NBITS:0]                 load_n_q;
  logic [MATRIX_REG_BITS-1:0]     store_addr_q;

  float_sp                        st_elem_q;
  logic [MBITS:0]                 st_i_q, st_m_q;
  logic [NBITS:0]                 st_j_q, st_n_q;
  logic                           st_valid_q, st_done_q, st_error_q;

  logic [MATRIX_REG_BITS:0]       eff_addr;
  logic [MBITS:0]                 eff_m;
  logic [NBITS:0]                 eff_n;
  logic                           wr_ok, wr_last;
  logic                           st_accept, st_ok, st_err, stream_go;
  logic [MATRIX_REG_BITS-1:0]     rd_addr;
  logic [MBITS:0]                 rd_i, rd_m;
  logic [NBITS:0]                 rd_j, rd_n;
  float_sp                        rd_elem;
  logic                           rd_last;

  always_comb begin
    // While loading, the latched target and dimensions govern every write.
    eff_addr = (state_q == RF_LOAD) ? load_addr_q : reg_load_addr_in;
    eff_m    = (state_q == RF_LOAD) ? load_m_q    : reg_m_load_size_in;
    eff_n    = (state_q == RF_LOAD) ? load_n_q    : reg_n_load_size_in;

    wr_ok = reg_load_req_in && (state_q != RF_STORE) &&
            (eff_addr < AddrLim) && (reg_i_load_loc_in < MLim) &&
            (reg_j_load_loc_in < NLim) && (eff_m != '0) && (eff_m <= MLim) &&
            (eff_n != '0) && (eff_n <= NLim);
    wr_last = wr_ok && (reg_i_load_loc_in == eff_m - 1'b1) &&
              (reg_j_load_loc_in == eff_n - 1'b1);

    st_accept = (state_q == RF_IDLE) && store_req_in && !reg_load_req_in && !load_pending_in;
    st_ok     = st_accept && (store_addr_in < AddrLim) &&
                valid_q[store_addr_in[MATRIX_REG_BITS-1:0]];
    st_err    = st_accept && !st_ok;
    stream_go = st_ok || ((state_q == RF_STORE) && !st_done_q);

    if (state_q == RF_STORE) begin
      rd_addr = store_addr_q;
      rd_m    = st_m_q;
      rd_n    = st_n_q;
      if (st_j_q == st_n_q - 1'b1) begin
        rd_i = st_i_q + 1'b1;
        rd_j = '0;
      end else begin
        rd_i = st_i_q;
        rd_j = st_j_q + 1'b1;
      end
    end else begin
      rd_addr = store_addr_in[MATRIX_REG_BITS-1:0];
      rd_m    = m_dim_q[store_addr_in[MATRIX_REG_BITS-1:0]];
      rd_n    = n_dim_q[store_addr_in[MATRIX_REG_BITS-1:0]];
      rd_i    = '0;
      rd_j    = '0;
    end
    rd_elem = mem_q[rd_addr][rd_i[MBITS-1:0]][rd_j[NBITS-1:0]];
    rd_last = (rd_i == rd_m - 1'b1) && (rd_j == rd_n - 1'b1);

    state_d = state_q;
    unique case (state_q)
      RF_IDLE: begin
        if (wr_last)    state_d = RF_IDLE;
        else if (wr_ok) state_d = RF_LOAD;
        else if (st_ok) state_d = RF_STORE;
      end
      RF_LOAD:  if (wr_last) state_d = RF_IDLE;
      RF_STORE: if (st_done_q) state_d = RF_IDLE;
      default:  state_d = RF_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= RF_IDLE;
      valid_q      <= '0;
      load_addr_q  <= '0;
      load_m_q     <= '0;
      load_n_q     <= '0;
      store_addr_q <= '0;
      st_elem_q    <= '0;
      st_i_q       <= '0;
      st_j_q       <= '0;
      st_m_q       <= '0;
      st_n_q       <= '0;
      st_valid_q   <= 1'b0;
      st_done_q    <= 1'b0;
      st_error_q   <= 1'b0;
      for (int k = 0; k < MATRIX_REGISTERS; k++) begin
        m_dim_q[k] <= '0;
        n_dim_q[k] <= '0;
      end
    end else begin
      state_q    <= state_d;
      st_error_q <= st_err;
      if (wr_ok && (state_q == RF_IDLE)) begin
        valid_q[eff_addr[MATRIX_REG_BITS-1:0]] <= 1'b0;
        load_addr_q <= eff_addr;
        load_m_q    <= eff_m;
        load_n_q    <= eff_n;
      end
      // Completing write wins over the clear above for a 1x1 matrix.
      if (wr_last) begin
        valid_q[eff_addr[MATRIX_REG_BITS-1:0]] <= 1'b1;
        m_dim_q[eff_addr[MATRIX_REG_BITS-1:0]] <= eff_m;
        n_dim_q[eff_addr[MATRIX_REG_BITS-1:0]] <= eff_n;
      end
      if (stream_go) begin
        if (state_q == RF_IDLE) store_addr_q <= rd_addr;
        st_elem_q  <= rd_elem;
        st_i_q     <= rd_i;
        st_j_q     <= rd_j;
        st_m_q     <= rd_m;
        st_n_q     <= rd_n;
        st_valid_q <= 1'b1;
        st_done_q  <= rd_last;
      end else begin
        st_elem_q  <= '0;
        st_i_q     <= '0;
        st_j_q     <= '0;
        st_m_q     <= '0;
        st_n_q     <= '0;
        st_valid_q <= 1'b0;
        st_done_q  <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst && wr_ok) begin
      mem_q[eff_addr[MATRIX_REG_BITS-1:0]][reg_i_load_loc_in[MBITS-1:0]]
           [reg_j_load_loc_in[NBITS-1:0]] <= reg_load_element_in;
    end
  end

  assign load_ready_out    = (state_q == RF_IDLE);
  assign store_element_out = st_elem_q;
  assign store_i_loc_out   = st_i_q;
  assign store_j_loc_out   = st_j_q;
  assign store_m_size_out  = st_m_q;
  assign store_n_size_out  = st_n_q;
  assign store_valid_out   = st_valid_q;
  assign store_done_out    = st_done_q;
  assign store_error_out   = st_error_q;
  assign matrix_valid_out  = valid_q;

endmodule

// File: tb/tb_mpu_register_file.sv
// Directed plus randomized bench for mpu_register_file against an array-based matrix model.

module tb_mpu_register_file;
  import global_defs::*;

  localparam int R = MATRIX_REGISTERS;

  logic                        clk = 1'b0;
  logic                        rst;
  logic                        reg_load_req_in;
  logic [MATRIX_REG_BITS:0]    reg_load_addr_in;
  logic [31:0]                 reg_load_element_in;
  logic [MBITS:0]              reg_i_load_loc_in;
  logic [NBITS:0]              reg_j_load_loc_in;
  logic [MBITS:0]              reg_m_load_size_in;
  logic [NBITS:0]              reg_n_load_size_in;
  logic                        load_pending_in;
  logic                        load_ready_out;
  logic                        store_req_in;
  logic [MATRIX_REG_BITS:0]    store_addr_in;
  logic [31:0]                 store_element_out;
  logic [MBITS:0]              store_i_loc_out;
  logic [NBITS:0]              store_j_loc_out;
  logic [MBITS:0]              store_m_size_out;
  logic [NBITS:0]              store_n_size_out;
  logic                        store_valid_out;
  logic                        store_done_out;
  logic                        store_error_out;
  logic [R-1:0]                matrix_valid_out;

  always #5 clk = ~clk;

  mpu_register_file dut (
    .clk                 (clk),
    .rst                 (rst),
    .reg_load_req_in     (reg_load_req_in),
    .reg_load_addr_in    (reg_load_addr_in),
    .reg_load_element_in (reg_load_element_in),
    .reg_i_load_loc_in   (reg_i_load_loc_in),
    .reg_j_load_loc_in   (reg_j_load_loc_in),
    .reg_m_load_size_in  (reg_m_load_size_in),
    .reg_n_load_size_in  (reg_n_load_size_in),
    .load_pending_in     (load_pending_in),
    .load_ready_out      (load_ready_out),
    .store_req_in        (store_req_in),
    .store_addr_in       (store_addr_in),
    .store_element_out   (store_element_out),
    .store_i_loc_out     (store_i_loc_out),
    .store_j_loc_out     (store_j_loc_out),
    .store_m_size_out    (store_m_size_out),
    .store_n_size_out    (store_n_size_out),
    .store_valid_out     (store_valid_out),
    .store_done_out      (store_done_out),
    .store_error_out     (store_error_out),
    .matrix_valid_out    (matrix_valid_out)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: plain matrices, completeness flags and dimensions.
  logic [31:0] mmem [R][M][N];
  bit          mvalid [R];
  int          mdm [R];
  int          mdn [R];
  bit          loading;
  int          lat_a, lat_m, lat_n;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  function automatic logic [R-1:0] valid_vec();
    logic [R-1:0] v;
    for (int k = 0; k < R; k++) v[k] = mvalid[k];
    return v;
  endfunction

  task automatic model_reset();
    loading = 1'b0;
    for (int k = 0; k < R; k++) begin
      mvalid[k] = 1'b0;
      mdm[k]    = 0;
      mdn[k]    = 0;
    end
  endtask

  task automatic model_write(input int a, input int i, input int j, input int m, input int n,
                             input logic [31:0] e);
    int ea, em, en;
    ea = loading ? lat_a : a;
    em = loading ? lat_m : m;
    en = loading ? lat_n : n;
    if (ea >= R || i >= M || j >= N || em == 0 || em > M || en == 0 || en > N) return;
    mmem[ea][i][j] = e;
    if (!loading) begin
      mvalid[ea] = 1'b0;
      lat_a = ea; lat_m = em; lat_n = en;
      loading = 1'b1;
    end
    if (i == em - 1 && j == en - 1) begin
      mvalid[ea] = 1'b1;
      mdm[ea] = em;
      mdn[ea] = en;
      loading = 1'b0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    reg_load_req_in = 1'b0;
    store_req_in    = 1'b0;
    load_pending_in = 1'b0;
  endtask

  task automatic drive_write(input int a, input int i, input int j, input int m, input int n,
                             input logic [31:0] e);
    reg_load_req_in     = 1'b1;
    reg_load_addr_in    = (MATRIX_REG_BITS + 1)'(a);
    reg_i_load_loc_in   = (MBITS + 1)'(i);
    reg_j_load_loc_in   = (NBITS + 1)'(j);
    reg_m_load_size_in  = (MBITS + 1)'(m);
    reg_n_load_size_in  = (NBITS + 1)'(n);
    reg_load_element_in = e;
  endtask

  task automatic write(input int a, input int i, input int j, input int m, input int n,
                       input logic [31:0] e);
    drive_write(a, i, j, m, n, e);
    model_write(a, i, j, m, n, e);
    tick();
    reg_load_req_in = 1'b0;
    check("load_ready", load_ready_out, !loading);
    check("matrix_valid", matrix_valid_out, valid_vec());
  endtask

  task automatic load_matrix(input int a, input int m, input int n, input bit stray_addr);
    for (int r = 0; r < m; r++)
      for (int c = 0; c < n; c++)
        write((stray_addr && (r + c) > 0) ? int'($urandom_range(0, R)) : a, r, c, m, n,
              $urandom);
  endtask

  task automatic garbage_write();
    drive_write($urandom_range(0, R), $urandom_range(0, M - 1), $urandom_range(0, N - 1),
                $urandom_range(1, M), $urandom_range(1, N), $urandom);
  endtask

  task automatic store(input int a);
    bit ok;
    int m, n;
    store_req_in    = 1'b1;
    store_addr_in   = (MATRIX_REG_BITS + 1)'(a);
    load_pending_in = 1'b0;
    ok = (a < R) && mvalid[a];
    tick();
    store_req_in = 1'b0;
    if (!ok) begin
      check("err_pulse", store_error_out, 1'b1);
      check("err_no_valid", store_valid_out, 1'b0);
      check("err_ready", load_ready_out, 1'b1);
      tick();
      check("err_cleared", store_error_out, 1'b0);
      check("err_no_valid2", store_valid_out, 1'b0);
      return;
    end
    m = mdm[a];
    n = mdn[a];
    for (int r = 0; r < m; r++) begin
      for (int c = 0; c < n; c++) begin
        if (r + c > 0) begin
          garbage_write();
          tick();
          reg_load_req_in = 1'b0;
        end
        check("st_valid", store_valid_out, 1'b1);
        check("st_elem", store_element_out, mmem[a][r][c]);
        check("st_i", store_i_loc_out, r);
        check("st_j", store_j_loc_out, c);
        check("st_m", store_m_size_out, m);
        check("st_n", store_n_size_out, n);
        check("st_done", store_done_out, (r == m - 1) && (c == n - 1));
        check("st_busy", load_ready_out, 1'b0);
      end
    end
    garbage_write();
    tick();
    reg_load_req_in = 1'b0;
    check("st_end_valid", store_valid_out, 1'b0);
    check("st_end_done", store_done_out, 1'b0);
    check("st_end_m", store_m_size_out, 0);
    check("st_end_ready", load_ready_out, 1'b1);
    check("st_end_mvalid", matrix_valid_out, valid_vec());
  endtask

  initial begin
    rst = 1'b0;
    idle_in();
    store_addr_in = '0;
    drive_write(0, 0, 0, 0, 0, 32'h0);
    reg_load_req_in = 1'b0;
    model_reset();
    tick();
    tick();
    rst = 1'b1;
    check("rst_ready", load_ready_out, 1'b1);
    check("rst_mvalid", matrix_valid_out, '0);
    check("rst_svalid", store_valid_out, 1'b0);
    check("rst_done", store_done_out, 1'b0);
    check("rst_err", store_error_out, 1'b0);
    check("rst_msize", store_m_size_out, 0);
    check("rst_elem", store_element_out, 0);

    // 2x3 load into register 1, then read it back.
    load_matrix(1, 2, 3, 1'b0);
    check("load_done_v1", matrix_valid_out[1], 1'b1);
    store(1);

    // Empty and out-of-range store targets.
    store(2);
    store(R);

    // Load beats a simultaneous store; pending load blocks stores.
    drive_write(3, 0, 0, 2, 2, $urandom);
    model_write(3, 0, 0, 2, 2, reg_load_element_in);
    store_req_in  = 1'b1;
    store_addr_in = 1;
    tick();
    idle_in();
    check("prio_ready", load_ready_out, 1'b0);
    check("prio_svalid", store_valid_out, 1'b0);
    tick();
    check("prio_svalid2", store_valid_out, 1'b0);
    check("prio_err", store_error_out, 1'b0);
    write(3, 0, 1, 2, 2, $urandom);
    write(3, 1, 0, 2, 2, $urandom);
    write(3, 1, 1, 2, 2, $urandom);
    store_req_in    = 1'b1;
    store_addr_in   = 1;
    load_pending_in = 1'b1;
    tick();
    check("pend_svalid", store_valid_out, 1'b0);
    tick();
    idle_in();
    check("pend_svalid2", store_valid_out, 1'b0);
    check("pend_err", store_error_out, 1'b0);
    check("pend_ready", load_ready_out, 1'b1);

    // Illegal dimensions are dropped; 1x1 completes in a single write.
    write(0, 0, 0, M + 1, 2, $urandom);
    write(0, 0, 0, 2, 0, $urandom);
    write(0, 0, 0, 1, 1, $urandom);
    check("one_v0", matrix_valid_out[0], 1'b1);
    store(0);
    store(3);

    // Randomized loads (with stray addresses while loading) and stores.
    for (int t = 0; t < 25; t++) begin
      if ($urandom_range(0, 3) == 0) write($urandom_range(0, R - 1), 0, 0, 0, 1, $urandom);
      load_matrix($urandom_range(0, R - 1), $urandom_range(1, M), $urandom_range(1, N),
                  $urandom_range(0, 1) == 1);
      store($urandom_range(0, R));
    end

    // Reset in the middle of a store.
    load_matrix(3, 2, 2, 1'b0);
    store_req_in  = 1'b1;
    store_addr_in = 3;
    tick();
    store_req_in = 1'b0;
    check("mid_st_v", store_valid_out, 1'b1);
    tick();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    model_reset();
    check("mid_st_abort", store_valid_out, 1'b0);
    check("mid_st_mvalid", matrix_valid_out, '0);

    // Reset during the fourth write of a 2x2 reload over a valid register.
    load_matrix(2, 2, 2, 1'b0);
    write(2, 0, 0, 2, 2, $urandom);
    write(2, 0, 1, 2, 2, $urandom);
    write(2, 1, 0, 2, 2, $urandom);
    drive_write(2, 1, 1, 2, 2, $urandom);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    reg_load_req_in = 1'b0;
    model_reset();
    check("rl_mvalid", matrix_valid_out, '0);
    check("rl_ready", load_ready_out, 1'b1);
    check("rl_svalid", store_valid_out, 1'b0);
    store(2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
